// File: rtl/eval_pkg.sv
// eval_pkg: mode encodings and ROM contents shared by the evaluation pipeline
package eval_pkg;
  localparam logic [1:0] MODE_SUB_INV = 2'd0;
  localparam logic [1:0] MODE_FULL    = 2'd1;
  localparam logic [1:0] MODE_ROM     = 2'd2;
  localparam logic [1:0] MODE_INV     = 2'd3;
  function automatic logic [7:0] rom_value(input int unsigned addr);
    return addr == 0 ? 8'd57  :
           addr == 1 ? 8'd61  :
           addr == 2 ? 8'd22  :
           addr == 3 ? 8'd98  :
           addr == 4 ? 8'd121 :
           addr == 5 ? 8'd17  :
           addr == 6 ? 8'd13  : 8'd3;
  endfunction
endpackage

// File: rtl/eval_rom.sv
// eval_rom: combinational lookup table, zero-extended to DATA_W
//   addr : lookup address
//   data : table value
module eval_rom #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  import eval_pkg::*;
  assign data = DATA_W'(rom_value(32'(addr)));
endmodule

// File: rtl/eval_pipe.sv
// eval_pipe: handshaked operand evaluation pipeline (S1 capture, S2 ROM + partial sum, S3 sum, output saturate)
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (in1, in2, mode)
//   out_valid/out_ready : result handshake (result)
//   idle                : no valid transaction anywhere, clock may be stopped
module eval_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter bit SAT    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              idle
);
  import eval_pkg::*;
  localparam int SW = DATA_W + 2;
  logic              adv;
  logic              s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d, out_v_q, out_v_d;
  logic [DATA_W-1:0] s1_in1_q, s1_in1_d, s1_inv2_q, s1_inv2_d;
  logic [1:0]        s1_mode_q, s1_mode_d, s2_mode_q, s2_mode_d;
  logic [DATA_W-1:0] s2_rom_q, s2_rom_d, result_q, result_d;
  logic [SW-1:0]     s2_p_q, s2_p_d, s3_sum_q, s3_sum_d;
  logic [DATA_W-1:0] rom_data;
  eval_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rom (
    .addr(s1_in1_q[ADDR_W-1:0]),
    .data(rom_data)
  );
  // Each data register loads only when the transaction entering it is valid,
  // so a drained pipeline holds every data bit constant.
  always_comb begin
    adv       = !out_v_q || out_ready;
    s1_v_d    = adv ? in_valid : s1_v_q;
    s2_v_d    = adv ? s1_v_q : s2_v_q;
    s3_v_d    = adv ? s2_v_q : s3_v_q;
    out_v_d   = adv ? s3_v_q : out_v_q;
    s1_in1_d  = adv && in_valid ? in1 : s1_in1_q;
    s1_inv2_d = adv && in_valid ? ~in2 : s1_inv2_q;
    s1_mode_d = adv && in_valid ? mode : s1_mode_q;
    s2_rom_d  = adv && s1_v_q ? rom_data : s2_rom_q;
    s2_mode_d = adv && s1_v_q ? s1_mode_q : s2_mode_q;
    s2_p_d    = !(adv && s1_v_q)       ? s2_p_q :
                s1_mode_q == MODE_ROM  ? SW'(s1_in1_q) :
                s1_mode_q == MODE_INV  ? SW'(s1_inv2_q) :
                                         SW'(s1_inv2_q) + SW'(s1_in1_q);
    s3_sum_d  = !(adv && s2_v_q)                                 ? s3_sum_q :
                s2_mode_q == MODE_FULL || s2_mode_q == MODE_ROM ? s2_p_q + SW'(s2_rom_q) :
                                                                  s2_p_q;
    // Wide sum either clamps or is truncated to the result width.
    result_d  = !(adv && s3_v_q)              ? result_q :
                SAT && |s3_sum_q[SW-1:DATA_W] ? '1 :
                                                s3_sum_q[DATA_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s3_v_q    <= 1'b0;
      out_v_q   <= 1'b0;
      s1_in1_q  <= '0;
      s1_inv2_q <= '0;
      s1_mode_q <= '0;
      s2_rom_q  <= '0;
      s2_mode_q <= '0;
      s2_p_q    <= '0;
      s3_sum_q  <= '0;
      result_q  <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s2_v_q    <= s2_v_d;
      s3_v_q    <= s3_v_d;
      out_v_q   <= out_v_d;
      s1_in1_q  <= s1_in1_d;
      s1_inv2_q <= s1_inv2_d;
      s1_mode_q <= s1_mode_d;
      s2_rom_q  <= s2_rom_d;
      s2_mode_q <= s2_mode_d;
      s2_p_q    <= s2_p_d;
      s3_sum_q  <= s3_sum_d;
      result_q  <= result_d;
    end
  assign in_ready  = adv;
  assign out_valid = out_v_q;
  assign result    = result_q;
  assign idle      = !(s1_v_q || s2_v_q || s3_v_q || out_v_q);
endmodule

// File: doc/eval_pipe.md
# eval_pipe

Parametrised, handshaked successor of the 8-bit evaluation kernel. Each accepted operand pair is evaluated under one of four per-transaction modes combining an inverted operand, a ROM lookup and a direct operand, through a fixed 3-stage pipeline with a valid/ready handshake. Stage registers load only when their stage holds a valid transaction (clock-enable gating), and the block reports idle so the upstream clock-gating controller can stop its clock. It sits between the operand source and the result consumer in the datapath.

## Interface
- DATA_W, 8, operand and result width (≥ 8)
- ADDR_W, 4, ROM address width; address = `in1[ADDR_W-1:0]`
- SAT, 0, 0 = results wrap modulo 2^DATA_W; 1 = results clamp to all-ones
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand transaction present
- in_ready  out  1  block can accept this cycle
- in1  in  DATA_W  operand 1 (also ROM address source)
- in2  in  DATA_W  operand 2 (used inverted)
- mode  in  2  0: in1+~in2; 1: rom+~in2+in1; 2: rom+in1; 3: ~in2
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  DATA_W  evaluated value
- idle  out  1  no valid transaction in any stage

## Operation
- One clock domain; reset is asynchronous and active-low. All stage valids, `out_valid` and `result` reset to 0; `idle` resets to 1.
- Advance: `adv = !out_valid || out_ready`. `in_ready = adv`. Accept when `in_valid && in_ready`.
- When `adv` = 1, every stage shifts one place. When `adv` = 0, all stages hold: nothing lost, nothing duplicated, `result` is stable.
- S1 captures in1, ~in2 and mode. Data registers load only for valid transactions; on bubbles, data is held and the valid bit cleared.
- S2: ROM read at `S1.in1[ADDR_W-1:0]`. Registers rom, in1, ~in2, mode and partial sum `p = ~in2 + in1` (mode 0/1), `in1` (mode 2) or `~in2` (mode 3).
- S3: `result = p + rom` for modes 1/2, else `p`.
- Arithmetic: internal sums DATA_W+2 bits, zero-extended. With SAT=0 the result is the truncated low DATA_W bits. With SAT=1, any sum ≥ 2^DATA_W gives all-ones.
- ROM contents (zero-extended to DATA_W): addr 0..6 = 57, 61, 22, 98, 121, 17, 13; all other addresses = 3.
- `idle` = NOR of all stage valids, including `out_valid`.
- Reset mid-operation: all in-flight transactions are discarded; no `out_valid` is issued afterwards for them.

## Timing
- Latency: a transaction accepted at edge N produces `out_valid`=1 with its result after edge N+3, when no stall occurs. Each stall cycle adds one cycle.
- Throughput: 1 transaction/cycle while `out_ready` is held at 1.
- Results emerge in acceptance order for all mixes of modes.
- Back-to-back: accepting while `out_valid && out_ready` is legal. The pipeline shifts and the new input enters S1 on the same edge.
- `in_ready` is combinational from `out_ready`. There is no other input-to-output combinational path.

## Structure
- Package `eval_pkg`:
  - mode encodings as named constants: MODE_SUB_INV, MODE_FULL, MODE_ROM, MODE_INV
  - ROM content function `rom_value(addr)`
- Sub-module `eval_rom`: combinational, parameters DATA_W and ADDR_W, built on `rom_value`.
- Top level `eval_pipe`: handshake, stage registers, adders, saturation.

## Test plan
- Mode 0, in1=5, in2=3, SAT=0 → result 1 at 3 cycles after acceptance. Same stimulus with SAT=1 → 255.
- Mode 1, in1=2, in2=0xF0 → 22+15+2 = 39. Mode 2, in1=4 → 125. Mode 2, in1=0x0E → 3+14 = 17. Mode 3, in2=0x0A → 245.
- Stream of 8 mixed-mode transactions with `out_ready` toggled 1/0 every cycle → all 8 results correct, in order, held stable during stalls. `in_ready` tracks `adv`.
- Assert `rst_n` low with 3 transactions in flight → `out_valid`=0, `result`=0 and `idle`=1 immediately, without waiting for a clock edge. After release, no stale outputs appear.
- DATA_W=12, ADDR_W=3, SAT=1, mode 1, in1=0xFFF, in2=0 (~in2=0xFFF) → result 0xFFF (clamped). Addr 7 → ROM value 3.
- Idle/gating: `in_valid`=0 for 5 cycles after drain → `idle`=1 and no stage data register changes value (checked by assertion).
